// File: rtl/fire_expand_1_sched.sv
// Sequencing controller for the shared fire2/fire3 expand-1x1 MAC array.
// Walks every output pixel of fire2 then fire3, one ACC phase plus one CLR cycle per pixel.
module fire_expand_1_sched #(
  parameter int WOUT  = 64,
  parameter int CHIN  = 16,
  parameter int PIX_W = $clog2(WOUT*WOUT),
  parameter int CH_W  = $clog2(CHIN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  skip_fire2,
  input  logic                  ifm_valid,
  output logic                  fire2_expand_1_en,
  output logic                  fire3_expand_1_en,
  output logic [PIX_W+CH_W-1:0] ifm_addr,
  output logic [CH_W-1:0]       weight_rom_address,
  output logic                  mac_ce,
  output logic                  clr_pulse,
  output logic                  ofm_sample,
  output logic [PIX_W-1:0]      ofm_addr,
  output logic                  fire2_expand_1_end,
  output logic                  fire3_expand_1_end,
  output logic                  busy
);

  localparam int AW = PIX_W + CH_W;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(WOUT*WOUT-1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHIN-1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN2 = 3'd1,
    S_SW   = 3'd2,
    S_RUN3 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               clr_q, clr_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               end2_q, end2_d;
  logic               end3_q, end3_d;
  logic               run_s;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      clr_q   <= 1'b0;
      ch_q    <= '0;
      pix_q   <= '0;
      end2_q  <= 1'b0;
      end3_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      end2_q  <= end2_d;
      end3_q  <= end3_d;
    end
  end

  // Next-state: ACC advances ch on accepted words; the last channel leaves ch at 0 for CLR
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    end2_d  = end2_q;
    end3_d  = end3_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = skip_fire2 ? S_RUN3 : S_RUN2;
          clr_d   = 1'b0;
          ch_d    = '0;
          pix_d   = '0;
          end2_d  = 1'b0;
          end3_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN2, S_RUN3: begin
        if (clr_q) begin
          clr_d = 1'b0;
          ch_d  = '0;
          if (pix_q == PIX_LAST) begin
            if (state_q == S_RUN2) begin
              state_d = S_SW;
              end2_d  = 1'b1;
            end else begin
              state_d = S_DONE;
              end3_d  = 1'b1;
            end
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end else if (ifm_valid) begin
          if (ch_q == CH_LAST) begin
            ch_d  = '0;
            clr_d = 1'b1;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          ch_d = ch_q;
        end
      end
      S_SW: begin
        state_d = S_RUN3;
        clr_d   = 1'b0;
        ch_d    = '0;
        pix_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        clr_d   = 1'b0;
        ch_d    = '0;
        pix_d   = '0;
        end2_d  = 1'b0;
        end3_d  = 1'b0;
      end
    endcase
  end

  // Datapath control decoded from state, phase and counters
  always_comb begin
    run_s              = (state_q == S_RUN2) || (state_q == S_RUN3);
    fire2_expand_1_en  = (state_q == S_RUN2);
    fire3_expand_1_en  = (state_q == S_RUN3);
    busy               = run_s || (state_q == S_SW);
    ifm_addr           = AW'(pix_q) * AW'(CHIN) + AW'(ch_q);
    weight_rom_address = ch_q;
    mac_ce             = run_s && !clr_q && ifm_valid;
    clr_pulse          = run_s && clr_q;
    ofm_sample         = run_s && clr_q;
    ofm_addr           = pix_q;
    fire2_expand_1_end = end2_q;
    fire3_expand_1_end = end3_q;
  end

endmodule

// File: tb/tb_fire_expand_1_sched.sv
// Bench for fire_expand_1_sched: expected cycle traces are generated from nested
// pixel/channel loops and compared against the DUT every cycle.
module tb_fire_expand_1_sched;

  localparam int WOUT  = 2;
  localparam int CHIN  = 4;
  localparam int NPIX  = WOUT * WOUT;
  localparam int PIX_W = $clog2(NPIX);
  localparam int CH_W  = $clog2(CHIN);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  skip_fire2 = 1'b0;
  logic                  ifm_valid = 1'b0;
  logic                  fire2_expand_1_en, fire3_expand_1_en;
  logic [PIX_W+CH_W-1:0] ifm_addr;
  logic [CH_W-1:0]       weight_rom_address;
  logic                  mac_ce, clr_pulse, ofm_sample;
  logic [PIX_W-1:0]      ofm_addr;
  logic                  fire2_expand_1_end, fire3_expand_1_end, busy;

  fire_expand_1_sched #(.WOUT(WOUT), .CHIN(CHIN)) dut (
    .clk(clk), .rst(rst), .start(start), .skip_fire2(skip_fire2), .ifm_valid(ifm_valid),
    .fire2_expand_1_en(fire2_expand_1_en), .fire3_expand_1_en(fire3_expand_1_en),
    .ifm_addr(ifm_addr), .weight_rom_address(weight_rom_address),
    .mac_ce(mac_ce), .clr_pulse(clr_pulse), .ofm_sample(ofm_sample), .ofm_addr(ofm_addr),
    .fire2_expand_1_end(fire2_expand_1_end), .fire3_expand_1_end(fire3_expand_1_end),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vin;
    bit en2, en3, mac, clr, smp, e2, e3, bsy;
    bit ad_chk, oa_chk;
    int ifm, wra, oaddr;
    int layer, pix, ch;
  } cyc_t;

  cyc_t tr[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   en2_cnt;
  int   done_len;

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @step %0d: observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en2"}, -1, 32'(fire2_expand_1_en), 32'd0);
    check({tag, "_en3"}, -1, 32'(fire3_expand_1_en), 32'd0);
    check({tag, "_ifm"}, -1, 32'(ifm_addr), 32'd0);
    check({tag, "_wra"}, -1, 32'(weight_rom_address), 32'd0);
    check({tag, "_mac"}, -1, 32'(mac_ce), 32'd0);
    check({tag, "_clr"}, -1, 32'(clr_pulse), 32'd0);
    check({tag, "_smp"}, -1, 32'(ofm_sample), 32'd0);
    check({tag, "_oaddr"}, -1, 32'(ofm_addr), 32'd0);
    check({tag, "_end2"}, -1, 32'(fire2_expand_1_end), 32'd0);
    check({tag, "_end3"}, -1, 32'(fire3_expand_1_end), 32'd0);
    check({tag, "_busy"}, -1, 32'(busy), 32'd0);
  endtask

  // Expected trace for one run: stall (s_*) forces ifm_valid low s_len times at one ACC point
  task automatic gen(input bit skip, input int s_layer, input int s_pix, input int s_ch,
                     input int s_len, input int pct);
    cyc_t c;
    int   left;
    bit   v;
    left = s_len;
    tr.delete();
    for (int lay = (skip ? 3 : 2); lay <= 3; lay++) begin
      if (lay == 3 && !skip) begin
        c = '{default: 0};
        c.vin = 1'($urandom_range(1)); c.e2 = 1'b1; c.bsy = 1'b1; c.layer = 1;
        tr.push_back(c);
      end
      for (int p = 0; p < NPIX; p++) begin
        for (int ch = 0; ch < CHIN; ch++) begin
          while (1) begin
            if (lay == s_layer && p == s_pix && ch == s_ch && left > 0) begin
              v = 1'b0;
              left--;
            end else begin
              v = ($urandom_range(99) >= pct);
            end
            c = '{default: 0};
            c.vin = v; c.en2 = (lay == 2); c.en3 = (lay == 3); c.mac = v;
            c.e2 = (lay == 3 && !skip); c.bsy = 1'b1; c.ad_chk = 1'b1;
            c.ifm = p * CHIN + ch; c.wra = ch; c.layer = lay; c.pix = p; c.ch = ch;
            tr.push_back(c);
            if (v) break;
          end
        end
        c = '{default: 0};
        c.vin = 1'($urandom_range(1)); c.en2 = (lay == 2); c.en3 = (lay == 3);
        c.clr = 1'b1; c.smp = 1'b1; c.e2 = (lay == 3 && !skip); c.bsy = 1'b1;
        c.ad_chk = 1'b1; c.oa_chk = 1'b1; c.ifm = p * CHIN; c.wra = 0; c.oaddr = p;
        c.layer = lay; c.pix = p; c.ch = -1;
        tr.push_back(c);
      end
    end
    c = '{default: 0};
    c.vin = 1'($urandom_range(1)); c.e2 = !skip; c.e3 = 1'b1;
    tr.push_back(c);
  endtask

  task automatic do_start(input bit skip);
    @(negedge clk);
    start = 1'b1;
    skip_fire2 = skip;
    ifm_valid = 1'($urandom_range(1));
    @(posedge clk);
  endtask

  // Replay the trace; optionally pulse start at start_at or assert rst at rst_at
  task automatic run_trace(input int start_at, input int rst_at);
    en2_cnt = 0;
    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk);
      ifm_valid  = tr[i].vin;
      start      = (i == start_at);
      skip_fire2 = 1'($urandom_range(1));
      #1;
      if (fire2_expand_1_en === 1'b1) en2_cnt++;
      check("en2", i, 32'(fire2_expand_1_en), 32'(tr[i].en2));
      check("en3", i, 32'(fire3_expand_1_en), 32'(tr[i].en3));
      check("mac_ce", i, 32'(mac_ce), 32'(tr[i].mac));
      check("clr", i, 32'(clr_pulse), 32'(tr[i].clr));
      check("ofm_sample", i, 32'(ofm_sample), 32'(tr[i].smp));
      check("end2", i, 32'(fire2_expand_1_end), 32'(tr[i].e2));
      check("end3", i, 32'(fire3_expand_1_end), 32'(tr[i].e3));
      check("busy", i, 32'(busy), 32'(tr[i].bsy));
      if (tr[i].ad_chk) begin
        check("ifm_addr", i, 32'(ifm_addr), 32'(tr[i].ifm));
        check("wrom_addr", i, 32'(weight_rom_address), 32'(tr[i].wra));
      end
      if (tr[i].oa_chk) check("ofm_addr", i, 32'(ofm_addr), 32'(tr[i].oaddr));
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        check_zero("rst_mid");
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int ridx;
    // Power-on reset, then idle hold
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_zero("idle");

    // start together with rst: rst wins
    @(negedge clk);
    start = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    #1;
    check_zero("start_rst");

    // Unstalled full run, then restart from DONE
    gen(1'b0, -1, -1, -1, 0, 0);
    check("unstalled_len", -1, 32'(tr.size()), 32'(2 * NPIX * (CHIN + 1) + 2));
    do_start(1'b0);
    run_trace(-1, -1);
    check("run2_len", -1, 32'(en2_cnt), 32'(NPIX * (CHIN + 1)));
    gen(1'b0, -1, -1, -1, 0, 0);
    do_start(1'b0);
    run_trace(-1, -1);

    // Three-cycle stall at pixel 1, channel 2 of fire2
    gen(1'b0, 2, 1, 2, 3, 0);
    do_start(1'b0);
    run_trace(-1, -1);
    check("stall_run2_len", -1, 32'(en2_cnt), 32'(NPIX * (CHIN + 1) + 3));

    // fire3 only
    gen(1'b1, -1, -1, -1, 0, 0);
    do_start(1'b1);
    run_trace(-1, -1);
    check("skip_en2_cnt", -1, 32'(en2_cnt), 32'd0);

    // start pulse at cycle 10 of RUN2 is ignored
    gen(1'b0, -1, -1, -1, 0, 0);
    do_start(1'b0);
    run_trace(9, -1);

    // Random stalls, random layer selection
    for (int k = 0; k < 4; k++) begin
      bit sk;
      sk = 1'($urandom_range(1));
      gen(sk, -1, -1, -1, 0, 30);
      do_start(sk);
      run_trace(-1, -1);
    end

    // Reset at pix 2, ch 1 of fire3, then a clean restart from fire2 pixel 0
    gen(1'b0, -1, -1, -1, 0, 25);
    ridx = -1;
    for (int i = 0; i < tr.size(); i++) begin
      if (ridx < 0 && tr[i].layer == 3 && tr[i].pix == 2 && tr[i].ch == 1) ridx = i;
    end
    do_start(1'b0);
    run_trace(-1, ridx);
    gen(1'b0, -1, -1, -1, 0, 0);
    do_start(1'b0);
    run_trace(-1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
